// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: write-back source and load-size encodings,
// default datapath width, and a small size helper.
package pipeline_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    WB_SEL_ZERO = 2'b00,
    WB_SEL_PC4  = 2'b01,
    WB_SEL_ALU  = 2'b10,
    WB_SEL_MEM  = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LS_B = 2'b00,
    LS_H = 2'b01,
    LS_W = 2'b10,
    LS_D = 2'b11
  } load_size_e;

  // Width in bits of an access of the given size encoding.
  function automatic int size_bits(input logic [1:0] s);
    return 8 << s;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load aligner: picks the accessed field out of a naturally
// aligned memory word (little-endian) and sign- or zero-extends it to XLEN.
// Misaligned offsets round down to the access size.
module load_align_ext
  import pipeline_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  data,
  input  logic [OFF_W-1:0] offset,
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  output logic [XLEN-1:0]  result
);

  logic [1:0]      eff_size;
  logic [OFF_W-1:0] lane_mask;
  logic [OFF_W-1:0] aligned;
  logic [XLEN-1:0] shifted;

  // Keep the low nbits of v and fill the rest with zeros or the field's sign
  // bit; a full-width field is passed through untouched.
  function automatic logic [XLEN-1:0] extend_field(input logic [XLEN-1:0] v,
                                                   input int nbits,
                                                   input logic uns);
    logic [XLEN-1:0] mask;
    logic            sgn;
    mask = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    sgn  = ~uns & (|(v & (XLEN'(1) << (nbits - 1))));
    return (v & mask) | (~mask & {XLEN{sgn}});
  endfunction

  // Align the field to bit 0 and extend it.
  always_comb begin
    eff_size = size;
    // A 32-bit datapath has no dword loads; treat them as word loads.
    if (XLEN == 32 && size == LS_D) eff_size = LS_W;
    lane_mask = OFF_W'((1 << eff_size) - 1);
    aligned   = offset & ~lane_mask;
    shifted   = data >> {aligned, 3'b000};
    result    = extend_field(shifted, size_bits(eff_size), is_unsigned);
  end

endmodule

// File: rtl/pipeline_wb_unit.sv
// Write-back stage: MEM/WB register with valid/stall/flush, write-source
// selection, x0 write suppression and the retired-instruction counter.
// All outputs come straight from flops.
module pipeline_wb_unit
  import pipeline_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_MEM,
  input  logic               stall_WB,
  input  logic               flush_WB,
  input  logic [1:0]         rf_wr_sel_MEM,
  input  logic [1:0]         load_size_MEM,
  input  logic               load_unsigned_MEM,
  input  logic [XLEN-1:0]    alu_result_MEM,
  input  logic [XLEN-1:0]    mem_data_MEM,
  input  logic [XLEN-1:0]    pc_MEM,
  input  logic [RADDR_W-1:0] rd_MEM,
  input  logic               reg_write_MEM,
  output logic [XLEN-1:0]    write_data_WB,
  output logic [RADDR_W-1:0] rd_WB,
  output logic               reg_write_WB,
  output logic               valid_WB,
  output logic [63:0]        instret
);

  localparam int OFF_W = $clog2(XLEN / 8);

  logic            acc;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] src_data;

  assign acc = valid_MEM & ~stall_WB & ~flush_WB;

  load_align_ext #(.XLEN(XLEN)) u_load_align_ext (
    .data        (mem_data_MEM),
    .offset      (alu_result_MEM[OFF_W-1:0]),
    .size        (load_size_MEM),
    .is_unsigned (load_unsigned_MEM),
    .result      (load_data)
  );

  // Register-file write source; pc+4 wraps at XLEN bits.
  always_comb begin
    src_data = '0;
    case (rf_wr_sel_MEM)
      WB_SEL_PC4: src_data = pc_MEM + XLEN'(4);
      WB_SEL_ALU: src_data = alu_result_MEM;
      WB_SEL_MEM: src_data = load_data;
      default:    src_data = '0;
    endcase
  end

  // MEM/WB slot: flush beats stall; a bubble only drops valid and write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_WB      <= 1'b0;
      reg_write_WB  <= 1'b0;
      write_data_WB <= '0;
      rd_WB         <= '0;
    end else if (flush_WB) begin
      valid_WB      <= 1'b0;
      reg_write_WB  <= 1'b0;
      write_data_WB <= '0;
      rd_WB         <= '0;
    end else if (!stall_WB) begin
      if (valid_MEM) begin
        valid_WB      <= 1'b1;
        rd_WB         <= rd_MEM;
        reg_write_WB  <= reg_write_MEM & (rd_MEM != '0);
        write_data_WB <= src_data;
      end else begin
        valid_WB     <= 1'b0;
        reg_write_WB <= 1'b0;
      end
    end
  end

  // Retired-instruction counter; counts every accepted instruction, wraps at 2^64.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= '0;
    end else if (acc) begin
      instret <= instret + 64'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_wb_unit.sv
// Bench for pipeline_wb_unit: a 64-bit and a 32-bit instance share stimulus.
// A behavioural model tracks the expected WB slot and instret of both; a
// negedge process compares every cycle, and directed steps pin literal values.
module tb_pipeline_wb_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_MEM, stall_WB, flush_WB;
  logic [1:0]  rf_wr_sel_MEM, load_size_MEM;
  logic        load_unsigned_MEM, reg_write_MEM;
  logic [63:0] alu, mem, pc;
  logic [4:0]  rd;

  logic [63:0] wd64, ir64, ir32;
  logic [31:0] wd32;
  logic [4:0]  rdo64, rdo32;
  logic        rw64, rw32, v64, v32;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, index 0 = XLEN 64, index 1 = XLEN 32.
  logic        e_valid [2];
  logic        e_rw    [2];
  logic [63:0] e_wd    [2];
  logic [4:0]  e_rd    [2];
  logic [63:0] e_ir    [2];
  logic        e_known [2];
  logic        model_ok = 1'b0;
  logic        preload  = 1'b0;

  always #5 clk = ~clk;

  pipeline_wb_unit #(.XLEN(64), .RADDR_W(5)) dut64 (
    .clk(clk), .reset(reset), .valid_MEM(valid_MEM), .stall_WB(stall_WB),
    .flush_WB(flush_WB), .rf_wr_sel_MEM(rf_wr_sel_MEM), .load_size_MEM(load_size_MEM),
    .load_unsigned_MEM(load_unsigned_MEM), .alu_result_MEM(alu), .mem_data_MEM(mem),
    .pc_MEM(pc), .rd_MEM(rd), .reg_write_MEM(reg_write_MEM),
    .write_data_WB(wd64), .rd_WB(rdo64), .reg_write_WB(rw64), .valid_WB(v64),
    .instret(ir64)
  );

  pipeline_wb_unit #(.XLEN(32), .RADDR_W(5)) dut32 (
    .clk(clk), .reset(reset), .valid_MEM(valid_MEM), .stall_WB(stall_WB),
    .flush_WB(flush_WB), .rf_wr_sel_MEM(rf_wr_sel_MEM), .load_size_MEM(load_size_MEM),
    .load_unsigned_MEM(load_unsigned_MEM), .alu_result_MEM(alu[31:0]),
    .mem_data_MEM(mem[31:0]), .pc_MEM(pc[31:0]), .rd_MEM(rd),
    .reg_write_MEM(reg_write_MEM),
    .write_data_WB(wd32), .rd_WB(rdo32), .reg_write_WB(rw32), .valid_WB(v32),
    .instret(ir32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Load result from byte arithmetic: size in bytes, offset rounded down.
  function automatic logic [63:0] ref_load(input logic [63:0] m, input logic [63:0] a,
                                           input int sz, input logic uns, input int xl);
    int nbytes, off;
    logic [63:0] f, msk;
    nbytes = 1 << sz;
    if (nbytes > xl / 8) nbytes = xl / 8;
    off = int'(a[5:0]) % (xl / 8);
    off = off - (off % nbytes);
    f   = m >> (off * 8);
    msk = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nbytes * 8)) - 64'd1);
    f   = f & msk;
    if (!uns && (nbytes * 8 < xl) && (((f >> (nbytes * 8 - 1)) & 64'd1) != 64'd0))
      f = f | ~msk;
    if (xl == 32) f = f & 64'hFFFF_FFFF;
    return f;
  endfunction

  function automatic logic [63:0] ref_src(input int xl, input logic [1:0] sel,
                                          input logic [63:0] p, input logic [63:0] a,
                                          input logic [63:0] m, input int sz,
                                          input logic uns);
    logic [63:0] xm;
    xm = (xl == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    case (sel)
      2'd1:    return (p + 64'd4) & xm;
      2'd2:    return a & xm;
      2'd3:    return ref_load(m & xm, a, sz, uns, xl);
      default: return 64'd0;
    endcase
  endfunction

  // Behavioural model of both instances, advanced on every clock edge.
  always @(posedge clk) begin
    if (reset) model_ok <= 1'b1;
    for (int w = 0; w < 2; w++) begin
      if (reset) begin
        e_valid[w] <= 1'b0; e_rw[w] <= 1'b0; e_wd[w] <= 64'd0; e_rd[w] <= 5'd0;
        e_ir[w] <= 64'd0; e_known[w] <= 1'b1;
      end else if (flush_WB) begin
        e_valid[w] <= 1'b0; e_rw[w] <= 1'b0; e_wd[w] <= 64'd0; e_rd[w] <= 5'd0;
        e_known[w] <= 1'b1;
      end else if (stall_WB) begin
        e_known[w] <= e_known[w];
      end else if (!valid_MEM) begin
        e_valid[w] <= 1'b0; e_rw[w] <= 1'b0; e_known[w] <= 1'b0;
      end else begin
        e_valid[w] <= 1'b1;
        e_rd[w]    <= rd;
        e_rw[w]    <= reg_write_MEM && (rd != 5'd0);
        e_wd[w]    <= ref_src(w == 1 ? 32 : 64, rf_wr_sel_MEM, pc, alu, mem,
                              int'(load_size_MEM), load_unsigned_MEM);
        e_ir[w]    <= e_ir[w] + 64'd1;
        e_known[w] <= 1'b1;
      end
    end
    if (preload && !reset) e_ir[1] <= 64'hFFFF_FFFF_FFFF_FFFF;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("valid64", {63'd0, v64}, {63'd0, e_valid[0]});
      chk("rw64", {63'd0, rw64}, {63'd0, e_rw[0]});
      chk("instret64", ir64, e_ir[0]);
      chk("valid32", {63'd0, v32}, {63'd0, e_valid[1]});
      chk("rw32", {63'd0, rw32}, {63'd0, e_rw[1]});
      chk("instret32", ir32, e_ir[1]);
      if (e_known[0]) begin
        chk("wd64", wd64, e_wd[0]);
        chk("rd64", {59'd0, rdo64}, {59'd0, e_rd[0]});
      end
      if (e_known[1]) begin
        chk("wd32", {32'd0, wd32}, e_wd[1]);
        chk("rd32", {59'd0, rdo32}, {59'd0, e_rd[1]});
      end
    end
  end

  task automatic drive(input logic v, input logic st, input logic fl, input logic [1:0] sel,
                       input logic [1:0] sz, input logic uns, input logic [63:0] a,
                       input logic [63:0] m, input logic [63:0] p, input logic [4:0] r,
                       input logic w);
    valid_MEM = v; stall_WB = st; flush_WB = fl; rf_wr_sel_MEM = sel;
    load_size_MEM = sz; load_unsigned_MEM = uns; alu = a; mem = m; pc = p;
    rd = r; reg_write_MEM = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] MEMV = 64'h8877_6655_4433_2211;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 2'd0, 2'd0, 0, 64'd0, 64'd0, 64'd0, 5'd0, 0);

    // Model pinned against hand-computed values.
    chk("model_lb7", ref_load(MEMV, 64'd7, 0, 0, 64), 64'hFFFF_FFFF_FFFF_FF88);
    chk("model_lhu2", ref_load(MEMV, 64'd2, 1, 1, 64), 64'h4433);
    chk("model_ld32", ref_load(64'h8000_0001, 64'd0, 3, 0, 32), 64'h8000_0001);

    // Reset held two cycles: every output zero.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_wd64", wd64, 64'd0);   chk("rst_v64", {63'd0, v64}, 64'd0);
      chk("rst_rw64", {63'd0, rw64}, 64'd0); chk("rst_rd64", {59'd0, rdo64}, 64'd0);
      chk("rst_ir64", ir64, 64'd0);   chk("rst_wd32", {32'd0, wd32}, 64'd0);
      chk("rst_ir32", ir32, 64'd0);   chk("rst_v32", {63'd0, v32}, 64'd0);
    end
    reset = 1'b0;

    // ALU pass-through.
    drive(1, 0, 0, 2'd2, 2'd0, 0, 64'h1234, 64'd0, 64'd0, 5'd5, 1);
    step();
    chk("alu_wd", wd64, 64'h1234); chk("alu_rd", {59'd0, rdo64}, 64'd5);
    chk("alu_rw", {63'd0, rw64}, 64'd1); chk("alu_v", {63'd0, v64}, 64'd1);
    chk("alu_ir", ir64, 64'd1);

    // Loads.
    drive(1, 0, 0, 2'd3, 2'd0, 0, 64'd7, MEMV, 64'd0, 5'd6, 1); step();
    chk("lb_off7", wd64, 64'hFFFF_FFFF_FFFF_FF88);
    drive(1, 0, 0, 2'd3, 2'd1, 1, 64'd2, MEMV, 64'd0, 5'd6, 1); step();
    chk("lhu_off2", wd64, 64'h4433);
    drive(1, 0, 0, 2'd3, 2'd2, 0, 64'd4, MEMV, 64'd0, 5'd6, 1); step();
    chk("lw_off4", wd64, 64'hFFFF_FFFF_8877_6655);
    drive(1, 0, 0, 2'd3, 2'd1, 1, 64'd3, MEMV, 64'd0, 5'd6, 1); step();
    chk("lhu_off3", wd64, 64'h4433);

    // x0 suppression and pc+4 wrap.
    drive(1, 0, 0, 2'd2, 2'd0, 0, 64'h55, 64'd0, 64'd0, 5'd0, 1); step();
    chk("x0_rw", {63'd0, rw64}, 64'd0); chk("x0_v", {63'd0, v64}, 64'd1);
    drive(1, 0, 0, 2'd1, 2'd0, 0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd7, 1); step();
    chk("pc4_wd64", wd64, 64'd0); chk("pc4_wd32", {32'd0, wd32}, 64'd0);
    chk("pc4_ir", ir64, 64'd7);

    // Three-cycle stall holds everything.
    drive(1, 1, 0, 2'd2, 2'd0, 0, 64'hDEAD, 64'd0, 64'd0, 5'd9, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wd", wd64, 64'd0); chk("stall_rd", {59'd0, rdo64}, 64'd7);
      chk("stall_v", {63'd0, v64}, 64'd1); chk("stall_ir", ir64, 64'd7);
    end

    // Flush with stall kills the slot.
    drive(1, 1, 1, 2'd2, 2'd0, 0, 64'hBEEF, 64'd0, 64'd0, 5'd9, 1); step();
    chk("flush_v", {63'd0, v64}, 64'd0); chk("flush_rw", {63'd0, rw64}, 64'd0);
    chk("flush_wd", wd64, 64'd0); chk("flush_ir", ir64, 64'd7);

    // Bubble.
    drive(0, 0, 0, 2'd2, 2'd0, 0, 64'h77, 64'd0, 64'd0, 5'd9, 1); step();
    chk("bubble_v", {63'd0, v64}, 64'd0); chk("bubble_rw", {63'd0, rw64}, 64'd0);
    chk("bubble_ir", ir64, 64'd7);

    // 32-bit specifics.
    drive(1, 0, 0, 2'd3, 2'd3, 0, 64'd0, 64'h8000_0001, 64'd0, 5'd3, 1); step();
    chk("x32_ld", {32'd0, wd32}, 64'h8000_0001);
    drive(1, 0, 0, 2'd3, 2'd0, 0, 64'd3, 64'h8000_0001, 64'd0, 5'd3, 1); step();
    chk("x32_lb3", {32'd0, wd32}, 64'hFFFF_FF80);
    chk("x64_lb3", wd64, 64'hFFFF_FFFF_FFFF_FF80);
    chk("x32_ir", ir32, 64'd9);

    // instret wrap on the 32-bit instance from a preloaded all-ones count.
    @(negedge clk); #1;
    valid_MEM = 1'b0;
    force dut32.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    preload = 1'b1;
    step();
    preload = 1'b0;
    chk("preload_ir32", ir32, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk); #1;
    release dut32.instret;
    drive(1, 0, 0, 2'd2, 2'd0, 0, 64'h10, 64'd0, 64'd0, 5'd4, 1);
    step();
    chk("wrap_ir32", ir32, 64'd0);
    chk("wrap_ir64", ir64, 64'd10);

    // Randomized traffic checked by the model each cycle.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 6) == 0,
            $urandom_range(0, 11) == 0, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                        : {$urandom, $urandom},
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      step();
    end
    reset = 1'b0;
    valid_MEM = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
